// File: rtl/rvne_decode_seq.sv
// Registered, stall-aware decoder for the RV32 + neuromorphic core.
// Vector-length loads are expanded into one control beat per element.
module rvne_decode_seq #(
  parameter int MAX_VL = 2,
  parameter int VL_W   = 2,
  parameter int IDX_W  = (MAX_VL < 1) ? 1 : MAX_VL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             stall,
  input  logic             flush,
  output logic             in_ready,
  output logic             ctrl_valid,
  output logic             branch,
  output logic             memtoreg,
  output logic             memwrite,
  output logic             alusrc,
  output logic             regwrite,
  output logic             wvr_write,
  output logic             svr_write,
  output logic             nsr_write,
  output logic             nsr_write1,
  output logic             nacc_vl,
  output logic             sor_nacc,
  output logic [1:0]       aluop,
  output logic [VL_W-1:0]  vl,
  output logic [VL_W-1:0]  ns_vl,
  output logic [IDX_W-1:0] elem_idx,
  output logic             last,
  output logic             illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_NSCFG  = 7'b0000001;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_VLD    = 7'b0000010;
  localparam logic [6:0] OPC_NSR    = 7'b0110010;

  localparam logic [2:0]       MAX_VL_F3 = 3'(MAX_VL);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef struct packed {
    logic            branch;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic            wvr_write;
    logic            svr_write;
    logic            nsr_write;
    logic            nsr_write1;
    logic            nacc_vl;
    logic            sor_nacc;
    logic [1:0]      aluop;
    logic [VL_W-1:0] vl;
    logic [VL_W-1:0] ns_vl;
    logic            illegal;
  } ctrl_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  ctrl_t            dec_s;
  logic [2:0]       dec_vl_s;
  logic             dec_bad_s;
  logic             dec_multi_s;
  logic [IDX_W-1:0] idx_inc_s;
  logic [IDX_W-1:0] last_idx_s;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;

  // Opcode/funct3 decode; an unknown or out-of-range op collapses to a bare illegal beat.
  always_comb begin
    dec_s     = '0;
    dec_vl_s  = 3'd0;
    dec_bad_s = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        dec_s.alusrc   = 1'b1;
        dec_s.memtoreg = 1'b1;
        dec_s.regwrite = 1'b1;
      end
      OPC_STORE: begin
        dec_s.alusrc   = 1'b1;
        dec_s.memwrite = 1'b1;
      end
      OPC_NSCFG: begin
        dec_s.aluop = 2'b10;
        dec_s.ns_vl = VL_W'(funct3);
        dec_bad_s   = (funct3 > MAX_VL_F3);
      end
      OPC_OP: begin
        if (funct3 == 3'b111) begin
          dec_s.nsr_write1 = 1'b1;
          dec_s.memtoreg   = 1'b1;
        end else begin
          dec_s.aluop    = 2'b10;
          dec_s.regwrite = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec_s.branch = 1'b1;
        dec_s.aluop  = 2'b01;
      end
      OPC_OPIMM: begin
        dec_s.alusrc   = 1'b1;
        dec_s.regwrite = 1'b1;
      end
      OPC_VLD: begin
        dec_s.alusrc   = 1'b1;
        dec_s.memtoreg = 1'b1;
        if (funct3 < 3'd3) begin
          dec_s.wvr_write = 1'b1;
          dec_vl_s        = funct3;
        end else if (funct3 <= 3'd5) begin
          dec_s.svr_write = 1'b1;
          dec_vl_s        = funct3 - 3'd3;
        end else begin
          dec_vl_s = 3'd0;
        end
        dec_s.vl  = VL_W'(dec_vl_s);
        dec_bad_s = (funct3 > 3'd5) || (dec_vl_s > MAX_VL_F3);
      end
      OPC_NSR: begin
        dec_s.nsr_write = 1'b1;
        dec_s.nacc_vl   = (funct3 == 3'b001);
        dec_s.sor_nacc  = (funct3 < 3'b100);
      end
      default: begin
        dec_bad_s = 1'b1;
      end
    endcase
    if (dec_bad_s) begin
      dec_s         = '0;
      dec_s.illegal = 1'b1;
      dec_vl_s      = 3'd0;
    end else begin
      dec_s.illegal = 1'b0;
    end
    dec_multi_s = (dec_vl_s != 3'd0);
  end

  // Sequencer: accept in IDLE, step element beats in SEQ; flush beats stall.
  always_comb begin
    idx_inc_s  = idx_q + IDX_ONE;
    last_idx_s = (IDX_ONE << ctrl_q.vl) - IDX_ONE;
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    last_d     = last_q;
    in_ready   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      ctrl_d  = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready = 1'b1;
          if (instr_valid) begin
            ctrl_d  = dec_s;
            valid_d = 1'b1;
            idx_d   = '0;
            last_d  = !dec_multi_s;
            state_d = dec_multi_s ? ST_SEQ : ST_IDLE;
          end else begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
          end
        end
        ST_SEQ: begin
          idx_d   = idx_inc_s;
          last_d  = (idx_inc_s == last_idx_s);
          state_d = (idx_inc_s == last_idx_s) ? ST_IDLE : ST_SEQ;
        end
        default: begin
          state_d = ST_IDLE;
          ctrl_d  = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign ctrl_valid = valid_q;
  assign branch     = ctrl_q.branch;
  assign memtoreg   = ctrl_q.memtoreg;
  assign memwrite   = ctrl_q.memwrite;
  assign alusrc     = ctrl_q.alusrc;
  assign regwrite   = ctrl_q.regwrite;
  assign wvr_write  = ctrl_q.wvr_write;
  assign svr_write  = ctrl_q.svr_write;
  assign nsr_write  = ctrl_q.nsr_write;
  assign nsr_write1 = ctrl_q.nsr_write1;
  assign nacc_vl    = ctrl_q.nacc_vl;
  assign sor_nacc   = ctrl_q.sor_nacc;
  assign aluop      = ctrl_q.aluop;
  assign vl         = ctrl_q.vl;
  assign ns_vl      = ctrl_q.ns_vl;
  assign illegal    = ctrl_q.illegal;
  assign elem_idx   = idx_q;
  assign last       = last_q;

endmodule

// File: tb/tb_rvne_decode_seq.sv
// Bench for rvne_decode_seq: a beat-queue model checked every cycle plus directed literal checks.
module tb_rvne_decode_seq;

  localparam int MAXV = 2;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, NSCFG = 7'b0000001,
                         OP = 7'b0110011, BRANCH = 7'b1100011, OPIMM = 7'b0010011,
                         VLD = 7'b0000010, NSR = 7'b0110010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, instr_valid, stall, flush;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic in_ready, ctrl_valid, branch, memtoreg, memwrite, alusrc, regwrite, wvr_write, svr_write;
  logic nsr_write, nsr_write1, nacc_vl, sor_nacc, last, illegal;
  logic [1:0] aluop, vl, ns_vl, elem_idx;
  logic d1_in_ready, d1_ctrl_valid, d1_branch, d1_memtoreg, d1_memwrite, d1_alusrc, d1_regwrite;
  logic d1_wvr_write, d1_svr_write, d1_nsr_write, d1_nsr_write1, d1_nacc_vl, d1_sor_nacc, d1_last, d1_illegal;
  logic [1:0] d1_aluop;
  logic [0:0] d1_vl, d1_ns_vl, d1_elem_idx;

  rvne_decode_seq dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
    .stall(stall), .flush(flush), .in_ready(in_ready), .ctrl_valid(ctrl_valid), .branch(branch),
    .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
    .wvr_write(wvr_write), .svr_write(svr_write), .nsr_write(nsr_write), .nsr_write1(nsr_write1),
    .nacc_vl(nacc_vl), .sor_nacc(sor_nacc), .aluop(aluop), .vl(vl), .ns_vl(ns_vl),
    .elem_idx(elem_idx), .last(last), .illegal(illegal)
  );

  rvne_decode_seq #(.MAX_VL(1), .VL_W(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
    .stall(stall), .flush(flush), .in_ready(d1_in_ready), .ctrl_valid(d1_ctrl_valid),
    .branch(d1_branch), .memtoreg(d1_memtoreg), .memwrite(d1_memwrite), .alusrc(d1_alusrc),
    .regwrite(d1_regwrite), .wvr_write(d1_wvr_write), .svr_write(d1_svr_write),
    .nsr_write(d1_nsr_write), .nsr_write1(d1_nsr_write1), .nacc_vl(d1_nacc_vl),
    .sor_nacc(d1_sor_nacc), .aluop(d1_aluop), .vl(d1_vl), .ns_vl(d1_ns_vl),
    .elem_idx(d1_elem_idx), .last(d1_last), .illegal(d1_illegal)
  );

  typedef struct packed {
    logic valid, branch, memtoreg, memwrite, alusrc, regwrite, wvr, svr, nsr, nsr1, nacc, sor;
    logic [1:0] aluop, vl, ns_vl, idx;
    logic last, illegal;
  } beat_t;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  beat_t q[$];
  beat_t exp_b = '0;
  beat_t act_b;

  assign act_b = {ctrl_valid, branch, memtoreg, memwrite, alusrc, regwrite, wvr_write, svr_write,
                  nsr_write, nsr_write1, nacc_vl, sor_nacc, aluop, vl, ns_vl, elem_idx, last, illegal};

  // Expected first beat of an op and how many element beats it expands to.
  function automatic beat_t decode(input logic [6:0] op, input logic [2:0] f3, output int n);
    beat_t b;
    int v;
    bit bad;
    b = '0; b.valid = 1'b1; n = 1; bad = 1'b0; v = 0;
    if (op == LOAD) begin b.alusrc = 1'b1; b.memtoreg = 1'b1; b.regwrite = 1'b1; end
    else if (op == STORE) begin b.alusrc = 1'b1; b.memwrite = 1'b1; end
    else if (op == NSCFG) begin b.aluop = 2'b10; b.ns_vl = f3[1:0]; bad = (f3 > MAXV); end
    else if (op == OP) begin
      if (f3 == 3'd7) begin b.nsr1 = 1'b1; b.memtoreg = 1'b1; end
      else begin b.aluop = 2'b10; b.regwrite = 1'b1; end
    end
    else if (op == BRANCH) begin b.branch = 1'b1; b.aluop = 2'b01; end
    else if (op == OPIMM) begin b.alusrc = 1'b1; b.regwrite = 1'b1; end
    else if (op == VLD) begin
      b.alusrc = 1'b1; b.memtoreg = 1'b1;
      if (f3 > 5) bad = 1'b1;
      else begin
        v = (f3 < 3) ? int'(f3) : int'(f3) - 3;
        if (f3 < 3) b.wvr = 1'b1; else b.svr = 1'b1;
        b.vl = 2'(v);
        if (v > MAXV) bad = 1'b1; else n = 2 ** v;
      end
    end
    else if (op == NSR) begin b.nsr = 1'b1; b.nacc = (f3 == 3'd1); b.sor = (f3 < 3'd4); end
    else bad = 1'b1;
    if (bad) begin b = '0; b.valid = 1'b1; b.illegal = 1'b1; n = 1; end
    return b;
  endfunction

  // Model: a queue of pending beats; an op is taken only when the queue is empty.
  always @(posedge clk) begin : model
    beat_t nb, t;
    int n;
    nb = exp_b;
    if (!rst_n || flush) begin q.delete(); nb = '0; end
    else if (stall) nb = exp_b;
    else if (q.size() != 0) nb = q.pop_front();
    else if (instr_valid) begin
      t = decode(opcode, funct3, n);
      for (int k = 0; k < n; k++) begin
        t.idx = 2'(k); t.last = (k == n - 1); q.push_back(t);
      end
      nb = q.pop_front();
    end else nb = '0;
    exp_b <= nb;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (act_b !== exp_b) begin
        errors++;
        $display("FAIL model_bundle t=%0t got %h expected %h", $time, act_b, exp_b);
      end
      checks++;
      if (in_ready !== ((q.size() == 0) && !stall && !flush)) begin
        errors++;
        $display("FAIL model_in_ready t=%0t got %b expected %b", $time, in_ready,
                 ((q.size() == 0) && !stall && !flush));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic st, input logic fl);
    instr_valid = v; opcode = op; funct3 = f3; stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [6:0] op, input logic [2:0] f3,
                     input logic st, input logic fl);
    drive(v, op, f3, st, fl);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_valid", ctrl_valid, 0); chk("reset_idx", elem_idx, 0); chk("reset_regwrite", regwrite, 0);
    rst_n = 1'b1;

    cyc(1'b1, LOAD, 3'd0, 1'b0, 1'b0);
    chk("load_valid", ctrl_valid, 1);
    chk("load_ctrl", {alusrc, memtoreg, regwrite, memwrite}, 4'b1110);
    chk("load_last", last, 1); chk("load_idx", elem_idx, 0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("load_gone", ctrl_valid, 0);

    cyc(1'b1, VLD, 3'b010, 1'b0, 1'b0);
    chk("maxvl1_illegal", d1_illegal, 1); chk("maxvl1_last", d1_last, 1); chk("maxvl1_wvr", d1_wvr_write, 0);
    for (int k = 0; k < 4; k++) begin
      chk("vld_idx", elem_idx, k);
      chk("vld_last", last, (k == 3) ? 1 : 0);
      chk("vld_wvr", wvr_write, 1);
      chk("vld_in_ready", in_ready, (k == 3) ? 1 : 0);
      if (k < 3) cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
      else cyc(1'b1, OP, 3'b000, 1'b0, 1'b0);
    end
    chk("op_after_vld", {regwrite, wvr_write, aluop}, 4'b1010); chk("op_after_idx", elem_idx, 0);

    cyc(1'b1, VLD, 3'b010, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("stall_pre_idx", elem_idx, 1);
    cyc(1'b0, 7'd0, 3'd0, 1'b1, 1'b0);
    chk("stall_hold_idx", elem_idx, 1); chk("stall_in_ready", in_ready, 0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("stall_idx2", elem_idx, 2); chk("stall_last2", last, 0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("stall_idx3", elem_idx, 3); chk("stall_last3", last, 1);

    cyc(1'b1, VLD, 3'b010, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 7'd0, 3'd0, 1'b1, 1'b1);
    tick();
    chk("flush_valid", ctrl_valid, 0); chk("flush_last", last, 0); chk("flush_idx", elem_idx, 0);
    drive(1'b1, STORE, 3'd0, 1'b0, 1'b0);
    #1;
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("store_memwrite", memwrite, 1); chk("store_regwrite", regwrite, 0);

    cyc(1'b1, 7'h7f, 3'd0, 1'b0, 1'b0);
    chk("ill_op", {ctrl_valid, illegal, last}, 3'b111);
    chk("ill_op_en", {regwrite, memwrite, branch, wvr_write}, 4'b0000);
    cyc(1'b1, VLD, 3'b110, 1'b0, 1'b0);
    chk("ill_vld", {illegal, last, wvr_write, svr_write}, 4'b1100);
    cyc(1'b1, NSCFG, 3'd3, 1'b0, 1'b0);
    chk("ill_nscfg", illegal, 1);
    cyc(1'b1, NSCFG, 3'd2, 1'b0, 1'b0);
    chk("nscfg", {illegal, ns_vl, aluop}, 5'b01010);
    cyc(1'b1, OP, 3'b111, 1'b0, 1'b0);
    chk("op111", {nsr_write1, regwrite, memtoreg, aluop}, 5'b10100);
    cyc(1'b1, NSR, 3'b001, 1'b0, 1'b0);
    chk("nsr001", {nsr_write, nacc_vl, sor_nacc}, 3'b111);
    cyc(1'b1, NSR, 3'b100, 1'b0, 1'b0);
    chk("nsr100", {nsr_write, nacc_vl, sor_nacc}, 3'b100);
    cyc(1'b1, BRANCH, 3'd0, 1'b0, 1'b0);
    chk("branch", {branch, aluop}, 3'b101);
    cyc(1'b1, VLD, 3'b100, 1'b0, 1'b0);
    chk("svr_beat0", {svr_write, vl, last}, 4'b1010);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("svr_beat1", {elem_idx, last}, 3'b011);

    cyc(1'b1, VLD, 3'b010, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    chk("rst_mid_seq", {ctrl_valid, wvr_write, vl, elem_idx, last}, 7'd0);
    rst_n = 1'b1;
    cyc(1'b1, OPIMM, 3'd0, 1'b0, 1'b0);
    chk("opimm", {alusrc, regwrite, memtoreg}, 3'b110);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvne_decode_seq.md
# rvne_decode_seq

Registered, stall-aware successor to the combinational instruction decoder for the RV32 + neuromorphic-extension core. It sits between the fetch/IF-ID register and the execute stage. It decodes the base and neuromorphic opcodes into a registered control bundle. Vector-length instructions are expanded into one control beat per element, with a per-element index, while upstream is held.

## Interface
- `MAX_VL` (default 2): largest legal vector-length code. An op with code v issues 2^v element beats.
- `VL_W` (default 2): width of the vector-length code, `vl` and `ns_vl`; must satisfy 2^VL_W > MAX_VL.
- `IDX_W` (default MAX_VL, min 1): width of `elem_idx`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `instr_valid` in 1: opcode/funct3 valid this cycle.
- `opcode` in 7, `funct3` in 3: instruction fields.
- `stall` in 1: downstream hold; freezes every register.
- `flush` in 1: kill the in-flight op; priority over `stall`.
- `in_ready` out 1: instruction accepted when `instr_valid && in_ready`.
- `ctrl_valid` out 1: control bundle valid this cycle.
- `branch, memtoreg, memwrite, alusrc, regwrite, wvr_write, svr_write, nsr_write, nsr_write1, nacc_vl, sor_nacc` out 1 each: registered controls.
- `aluop` out 2; `vl` out VL_W; `ns_vl` out VL_W: registered fields.
- `elem_idx` out IDX_W: element number of the current beat.
- `last` out 1: final beat of the op; 1 for single-beat ops.
- `illegal` out 1: accepted op was unknown or had an out-of-range VL code.

## Operation
- Decode (all unlisted outputs 0):
  - LOAD 0000011: alusrc, memtoreg, regwrite.
  - STORE 0100011: alusrc, memwrite.
  - NSCFG 0000001: aluop=10, ns_vl=funct3[VL_W-1:0]. Illegal if funct3 > MAX_VL.
  - OP 0110011: aluop=10, regwrite. If funct3=111: regwrite=0, nsr_write1=1, memtoreg=1, aluop=00.
  - BRANCH 1100011: branch, aluop=01.
  - OP-IMM 0010011: alusrc, regwrite.
  - VLD 0000010: alusrc, memtoreg. funct3<3 sets wvr_write, vl=funct3. funct3 in 3..5 sets svr_write, vl=funct3-3. Illegal if funct3>5 or vl>MAX_VL.
  - NSR 0110010: nsr_write. nacc_vl when funct3=001. sor_nacc when funct3<100.
  - Any other opcode: illegal.
- An illegal op is accepted as a single beat with `ctrl_valid=1`, `illegal=1`, `last=1` and all write/branch enables 0.
- All outputs other than `in_ready` are registered. When `ctrl_valid=0`, every enable, `illegal` and `last` is 0.
- Beat count: VLD ops issue 2^vl beats. All other ops issue 1 beat.
- FSM states:
  - IDLE: `in_ready = !stall && !flush`. On accept, load the bundle with elem_idx=0 and last=(count==1). Go to SEQ if count>1. With no accept, ctrl_valid←0.
  - SEQ: `in_ready=0`. Each non-stalled cycle: elem_idx+1, bundle held, last←(elem_idx+1==count-1). The edge that loads the last beat returns to IDLE.
- Stall: all state and outputs hold. `in_ready=0`.
- Flush, in any state and regardless of stall: ctrl_valid←0, all enables←0, elem_idx←0, last←0, state←IDLE. No instruction is accepted that cycle.
- Reset (`rst_n=0` at an edge, including mid-sequence): state IDLE, all outputs 0, `elem_idx=0`.

## Timing
- Latency is 1 cycle: an op accepted at edge N shows beat 0 in cycle N+1 and beat k in cycle N+1+k, absent stalls.
- An op with count C occupies SEQ during cycles N+1..N+C-1. `in_ready` rises in cycle N+C, so consecutive ops issue with zero bubbles.
- Each stalled cycle extends every subsequent timing point by one.
- `in_ready` is combinational from `stall`, `flush` and state only. It has no dependency on `opcode`.

## Test plan
- Reset, then LOAD accepted at cycle 1: cycle 2 shows ctrl_valid=1, alusrc=memtoreg=regwrite=1, last=1, elem_idx=0. Cycle 3 shows ctrl_valid=0.
- VLD funct3=010 (vl=2, wvr_write): 4 beats in cycles 2..5 with elem_idx 0,1,2,3 and last only in cycle 5. in_ready=0 in cycles 2..4 and 1 in cycle 5. An OP accepted in cycle 5 appears in cycle 6.
- Same VLD with stall=1 in cycle 3: elem_idx stays 1 in cycles 3 and 4. Last beat moves to cycle 6.
- Flush asserted with stall in cycle 3 of a 4-beat VLD: cycle 4 shows ctrl_valid=0 and in_ready=1. A following STORE decodes memwrite=1.
- Opcode 1111111 and VLD funct3=110: each gives one beat with illegal=1, last=1, all enables 0. With MAX_VL=1, VLD funct3=010 is also illegal.
- OP funct3=111 gives nsr_write1=1, regwrite=0, memtoreg=1, aluop=00. rst_n=0 mid-SEQ gives all outputs 0 next cycle.
